// File: rtl/text_frame_pkg.sv
// Shared types, control-character codes and cell addressing for the text frame store.
// Logical rows are rotated by a base row so that scrolling needs no data movement.
package text_frame_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, CLEAR_ROW} state_t;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   typedef struct packed {
      logic        ok;
      logic [31:0] idx;
   } cell_ref_t;

   // Physical row is (row + base) mod rows; base < rows, so one subtraction is enough.
   function automatic cell_ref_t cell_index(input int unsigned row, input int unsigned col,
                                            input int unsigned base, input int unsigned rows,
                                            input int unsigned cols);
      cell_ref_t   r;
      int unsigned prow;
      prow = row + base;
      if (prow >= rows)
         prow = prow - rows;
      r.ok  = (row < rows) && (col < cols);
      r.idx = r.ok ? (prow * cols + col) : 32'd0;
      return r;
   endfunction

endpackage

// File: rtl/text_frame_clear_seq.sv
// Clear engine: walks linear cells writing the fill value, one per clock, and flags busy.
// With TEXT_FRAME_RAM_SCROLL_EN defined it can also blank a single row starting at row_start.
module text_frame_clear_seq
   import text_frame_pkg::*;
#(
   parameter int CELLS = 128,
   parameter int COLS  = 4,
   parameter int CNTW  = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_req,
`ifdef TEXT_FRAME_RAM_SCROLL_EN
   input  logic            scroll,
   input  logic [CNTW-1:0] row_start,
`endif
   output logic [CNTW-1:0] clr_addr,
   output logic            clr_we,
   output logic            busy
);

   state_t          state_reg;
   logic [CNTW-1:0] cnt_reg;
   logic [CNTW-1:0] end_reg;
   logic            busy_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= CLEAR;
         cnt_reg   <= '0;
         end_reg   <= CNTW'(CELLS - 1);
         busy_reg  <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  state_reg <= CLEAR;
                  cnt_reg   <= '0;
                  end_reg   <= CNTW'(CELLS - 1);
                  busy_reg  <= 1'b1;
               end
`ifdef TEXT_FRAME_RAM_SCROLL_EN
               else if (scroll) begin
                  state_reg <= CLEAR_ROW;
                  cnt_reg   <= row_start;
                  end_reg   <= row_start + CNTW'(COLS - 1);
                  busy_reg  <= 1'b1;
               end
`endif
            end
            CLEAR, CLEAR_ROW: begin
               if (cnt_reg == end_reg) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_addr = cnt_reg;
   assign clr_we   = (state_reg != IDLE);
   assign busy     = busy_reg;

endmodule

// File: rtl/text_frame_ram.sv
// Character-cell frame store: one write port, one registered read port, row-0 taps, clear engine.
// Define TEXT_FRAME_RAM_SCROLL_EN to add the scroll input and the rotating base row.
module text_frame_ram
   import text_frame_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ROWS        = 32,
   parameter int                    COLS        = 4,
   parameter int                    NUM_TAPS    = 2,
   parameter logic [DATA_WIDTH-1:0] FILL        = '0,
   parameter int                    FILTER_CTRL = 1,
   localparam int                   RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int                   CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clr_req,
`ifdef TEXT_FRAME_RAM_SCROLL_EN
   input  logic                           scroll,
`endif
   input  logic                           we,
   input  logic [RW-1:0]                  w_row,
   input  logic [CW-1:0]                  w_col,
   input  logic [DATA_WIDTH-1:0]          din,
   input  logic [RW-1:0]                  r_row,
   input  logic [CW-1:0]                  r_col,
   output logic [DATA_WIDTH-1:0]          dout,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] taps,
   output logic                           wr_ok,
   output logic                           busy
);

   localparam int CELLS = ROWS * COLS;
   localparam int CNTW  = (CELLS > 1) ? $clog2(CELLS) : 1;

   logic [DATA_WIDTH-1:0] mem [CELLS];
   logic [DATA_WIDTH-1:0] dout_reg;
   logic [DATA_WIDTH-1:0] taps_reg [NUM_TAPS];
   logic                  wr_ok_reg;
   logic [RW-1:0]         base;
   logic [CNTW-1:0]       clr_addr;
   logic                  clr_we;
   logic                  scroll_go;
   cell_ref_t             w_ref;
   cell_ref_t             r_ref;
   cell_ref_t             tap_ref [NUM_TAPS];
   logic                  is_ctrl;
   logic                  commit;

`ifdef TEXT_FRAME_RAM_SCROLL_EN
   logic [RW-1:0] base_reg;
   cell_ref_t     base_ref;
   logic          unused_base_ref;

   assign base      = base_reg;
   assign scroll_go = scroll && !busy && !clr_req;
   assign base_ref  = cell_index(32'd0, 32'd0, 32'(base), ROWS, COLS);
   assign unused_base_ref = ^{base_ref.ok, base_ref.idx[31:CNTW]};

   always_ff @(posedge clk) begin
      if (reset || (clr_req && !busy))
         base_reg <= '0;
      else if (scroll_go)
         base_reg <= (32'(base_reg) == ROWS - 1) ? '0 : base_reg + 1'b1;
   end

   text_frame_clear_seq #(.CELLS(CELLS), .COLS(COLS), .CNTW(CNTW)) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clr_req   (clr_req),
      .scroll    (scroll),
      .row_start (base_ref.idx[CNTW-1:0]),
      .clr_addr  (clr_addr),
      .clr_we    (clr_we),
      .busy      (busy)
   );
`else
   assign base      = '0;
   assign scroll_go = 1'b0;

   text_frame_clear_seq #(.CELLS(CELLS), .COLS(COLS), .CNTW(CNTW)) u_clear_seq (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_addr (clr_addr),
      .clr_we   (clr_we),
      .busy     (busy)
   );
`endif

   assign w_ref   = cell_index(32'(w_row), 32'(w_col), 32'(base), ROWS, COLS);
   assign r_ref   = cell_index(32'(r_row), 32'(r_col), 32'(base), ROWS, COLS);
   assign is_ctrl = (FILTER_CTRL != 0) &&
                    ((din == DATA_WIDTH'(CR)) || (din == DATA_WIDTH'(LF)));
   // A write racing a clear/scroll start is dropped so it cannot land behind the engine.
   assign commit  = !reset && !busy && !clr_req && !scroll_go &&
                    we && w_ref.ok && !is_ctrl;

   always_ff @(posedge clk) begin
      if (clr_we && !reset)
         mem[clr_addr] <= FILL;
      else if (commit)
         mem[w_ref.idx[CNTW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_reg  <= '0;
         wr_ok_reg <= 1'b0;
      end else begin
         dout_reg  <= r_ref.ok ? mem[r_ref.idx[CNTW-1:0]] : '0;
         wr_ok_reg <= commit;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
         assign tap_ref[gi] = cell_index(32'd0, 32'(gi), 32'(base), ROWS, COLS);

         always_ff @(posedge clk) begin
            if (reset)
               taps_reg[gi] <= '0;
            else
               taps_reg[gi] <= mem[tap_ref[gi].idx[CNTW-1:0]];
         end

         assign taps[gi*DATA_WIDTH +: DATA_WIDTH] = taps_reg[gi];
      end
   endgenerate

   logic unused_idx_bits;
   always_comb begin
      unused_idx_bits = ^{w_ref.idx[31:CNTW], r_ref.idx[31:CNTW]};
      for (int k = 0; k < NUM_TAPS; k++)
         unused_idx_bits = unused_idx_bits ^ (^{tap_ref[k].ok, tap_ref[k].idx[31:CNTW]});
   end

   assign dout  = dout_reg;
   assign wr_ok = wr_ok_reg;

endmodule

// File: tb/tb_text_frame_ram.sv
// Directed bench for text_frame_ram: default instance, unfiltered instance sharing its inputs,
// and a 5x3 instance with a non-zero fill value.
module tb_text_frame_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instances A (filtered) and B (unfiltered) share stimulus.
   logic        reset, clr_req, we, scroll;
   logic [4:0]  w_row, r_row;
   logic [1:0]  w_col, r_col;
   logic [7:0]  din;
   logic [7:0]  dout_a, dout_b;
   logic [15:0] taps_a, taps_b;
   logic        wr_ok_a, wr_ok_b, busy_a, busy_b;

   // Instance C: 5 rows x 3 cols, fill '.'.
   logic        reset_c, clr_c, we_c, scroll_c;
   logic [2:0]  w_row_c, r_row_c;
   logic [1:0]  w_col_c, r_col_c;
   logic [7:0]  din_c, dout_c;
   logic [15:0] taps_c;
   logic        wr_ok_c, busy_c;

   text_frame_ram u_dut_a (
      .clk(clk), .reset(reset), .clr_req(clr_req),
`ifdef TEXT_FRAME_RAM_SCROLL_EN
      .scroll(scroll),
`endif
      .we(we), .w_row(w_row), .w_col(w_col), .din(din), .r_row(r_row), .r_col(r_col),
      .dout(dout_a), .taps(taps_a), .wr_ok(wr_ok_a), .busy(busy_a)
   );

   text_frame_ram #(.FILTER_CTRL(0)) u_dut_b (
      .clk(clk), .reset(reset), .clr_req(clr_req),
`ifdef TEXT_FRAME_RAM_SCROLL_EN
      .scroll(scroll),
`endif
      .we(we), .w_row(w_row), .w_col(w_col), .din(din), .r_row(r_row), .r_col(r_col),
      .dout(dout_b), .taps(taps_b), .wr_ok(wr_ok_b), .busy(busy_b)
   );

   text_frame_ram #(.ROWS(5), .COLS(3), .FILL(8'h2E)) u_dut_c (
      .clk(clk), .reset(reset_c), .clr_req(clr_c),
`ifdef TEXT_FRAME_RAM_SCROLL_EN
      .scroll(scroll_c),
`endif
      .we(we_c), .w_row(w_row_c), .w_col(w_col_c), .din(din_c), .r_row(r_row_c), .r_col(r_col_c),
      .dout(dout_c), .taps(taps_c), .wr_ok(wr_ok_c), .busy(busy_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int n, nc, bad;
      reset = 1'b1; clr_req = 1'b0; we = 1'b0; scroll = 1'b0;
      w_row = '0; w_col = '0; din = '0; r_row = '0; r_col = '0;
      reset_c = 1'b1; clr_c = 1'b0; we_c = 1'b0; scroll_c = 1'b0;
      w_row_c = '0; w_col_c = '0; din_c = '0; r_row_c = '0; r_col_c = '0;

      repeat (3) tick();
      chk("rst_dout", dout_a, 0);
      chk("rst_taps", taps_a, 0);
      chk("rst_wr_ok", wr_ok_a, 0);
      chk("rst_busy", busy_a, 1);
      chk("rst_busy_c", busy_c, 1);
      $display("reset held: busy_a=%0b busy_c=%0b", busy_a, busy_c);

      // Count busy cycles after release for A (128 cells) and C (15 cells).
      reset = 1'b0; reset_c = 1'b0;
      n = 0; nc = 0;
      while (busy_a && n < 300) begin
         n++;
         if (busy_c) nc++;
         tick();
      end
      chk("init_busy_cycles", n, 128);
      chk("init_busy_cycles_c", nc, 15);
      $display("reset release: busy cycles a=%0d c=%0d", n, nc);

      for (int i = 0; i < 128; i++) begin
         r_row = 5'(i / 4); r_col = 2'(i % 4);
         tick();
         chk($sformatf("sweep_cell%0d", i), dout_a, 0);
      end
      $display("post-clear sweep of 128 cells done");

      // Write with a same-cycle read of the same cell.
      we = 1'b1; w_row = 5'd2; w_col = 2'd3; din = 8'h41; r_row = 5'd2; r_col = 2'd3;
      tick();
      chk("wr23_ok", wr_ok_a, 1);
      chk("wr23_old_read", dout_a, 0);
      we = 1'b0;
      tick();
      chk("rd23", dout_a, 8'h41);
      chk("wr_ok_drop", wr_ok_a, 0);
      $display("write (2,3)=41: dout=%0h", dout_a);

      // Control characters: A filters, B stores.
      we = 1'b1; w_row = 5'd1; w_col = 2'd1; din = 8'h0D;
      tick();
      chk("cr_wr_ok_a", wr_ok_a, 0);
      chk("cr_wr_ok_b", wr_ok_b, 1);
      w_col = 2'd2; din = 8'h0A;
      tick();
      chk("lf_wr_ok_a", wr_ok_a, 0);
      chk("lf_wr_ok_b", wr_ok_b, 1);
      we = 1'b0; r_row = 5'd1; r_col = 2'd1;
      tick();
      chk("cr_rd_a", dout_a, 0);
      chk("cr_rd_b", dout_b, 8'h0D);
      r_col = 2'd2;
      tick();
      chk("lf_rd_a", dout_a, 0);
      chk("lf_rd_b", dout_b, 8'h0A);
      $display("ctrl chars: a=%0h b=%0h", dout_a, dout_b);

      // Row-0 taps.
      we = 1'b1; w_row = 5'd0; w_col = 2'd0; din = 8'h11;
      tick();
      w_col = 2'd1; din = 8'h22;
      tick();
      we = 1'b0;
      tick();
      chk("taps_written", taps_a, 16'h2211);
      $display("taps: %04h", taps_a);

      // Runtime clear; writes attempted throughout are dropped.
      clr_req = 1'b1; we = 1'b1; w_row = 5'd0; w_col = 2'd0; din = 8'h99;
      tick();
      clr_req = 1'b0;
      chk("clr_busy", busy_a, 1);
      chk("clr_same_cycle_wr", wr_ok_a, 0);
      n = 0; bad = 0;
      while (busy_a && n < 300) begin
         n++;
         if (wr_ok_a) bad++;
         tick();
      end
      we = 1'b0;
      chk("clr_busy_cycles", n, 128);
      chk("clr_writes_committed", bad, 0);
      r_row = 5'd0; r_col = 2'd0;
      tick();
      chk("clr_rd00", dout_a, 0);
      chk("clr_taps", taps_a, 0);
      r_row = 5'd2; r_col = 2'd3;
      tick();
      chk("clr_rd23", dout_a, 0);
      $display("runtime clear: busy cycles=%0d", n);

      // Instance C: out-of-range writes and reads.
      we_c = 1'b1; w_row_c = 3'd6; w_col_c = 2'd0; din_c = 8'h33;
      tick();
      chk("c_row6_wr_ok", wr_ok_c, 0);
      w_row_c = 3'd1; w_col_c = 2'd3; din_c = 8'h44;
      tick();
      chk("c_col3_wr_ok", wr_ok_c, 0);
      w_row_c = 3'd4; w_col_c = 2'd2; din_c = 8'h55;
      tick();
      chk("c_wr42_ok", wr_ok_c, 1);
      we_c = 1'b0; r_row_c = 3'd6; r_col_c = 2'd0;
      tick();
      chk("c_rd_row6", dout_c, 0);
      r_row_c = 3'd4; r_col_c = 2'd2;
      tick();
      chk("c_rd42", dout_c, 8'h55);
      r_row_c = 3'd2; r_col_c = 2'd0;
      tick();
      chk("c_rd20_fill", dout_c, 8'h2E);
      chk("c_taps_fill", taps_c, 16'h2E2E);
      $display("small instance: out-of-range handled, dout=%0h", dout_c);

      // Instance C: reset in the middle of a clear restarts it from cell 0.
      clr_c = 1'b1;
      tick();
      clr_c = 1'b0;
      repeat (5) tick();
      reset_c = 1'b1;
      tick();
      chk("c_midrst_busy", busy_c, 1);
      reset_c = 1'b0;
      n = 0;
      while (busy_c && n < 100) begin
         n++;
         tick();
      end
      chk("c_midrst_busy_cycles", n, 15);
      r_row_c = 3'd4; r_col_c = 2'd2;
      tick();
      chk("c_midrst_rd42", dout_c, 8'h2E);
      $display("small instance mid-clear reset: busy cycles=%0d", n);

`ifdef TEXT_FRAME_RAM_SCROLL_EN
      we = 1'b1; w_row = 5'd0; w_col = 2'd0; din = 8'h55;
      tick();
      w_row = 5'd1; din = 8'h66;
      tick();
      we = 1'b0; scroll = 1'b1;
      tick();
      scroll = 1'b0;
      n = 0;
      while (busy_a && n < 50) begin
         n++;
         tick();
      end
      chk("scroll_busy_cycles", n, 4);
      r_row = 5'd31; r_col = 2'd0;
      tick();
      chk("scroll_rd31", dout_a, 0);
      r_row = 5'd0;
      tick();
      chk("scroll_rd0", dout_a, 8'h66);
      chk("scroll_tap0", taps_a[7:0], 8'h66);
      $display("scroll: busy cycles=%0d row0=%0h", n, dout_a);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/text_frame_ram.md
Name: text_frame_ram

Overview:
- Parametrised character-cell frame store for the text-display path: one write port from the keyboard/UART side, one random read port for the video scanner, and NUM_TAPS fixed taps on row 0 for status logic.
- Sequential clear engine (one cell per clock) avoids blanking the monitor. Clear is triggered by reset or a runtime request, and a busy flag is exported.
- Optional CR/LF write filtering.

Parameters:
- DATA_WIDTH, 8, bits per cell.
- ROWS, 32, number of text rows; need not be a power of two.
- COLS, 4, number of cells per row; need not be a power of two.
- NUM_TAPS, 2, number of fixed taps on row 0, cols 0..NUM_TAPS-1; must satisfy 1 <= NUM_TAPS <= COLS.
- FILL, 0, value written by the clear engine.
- FILTER_CTRL, 1, when 1, writes of 8'h0D or 8'h0A are dropped.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset; synchronous, active-high.
- clr_req, in, 1, single-cycle pulse that starts a full clear.
- we, in, 1, write enable.
- w_row, in, RW=$clog2(ROWS), write row.
- w_col, in, CW=$clog2(COLS), write column.
- din, in, DATA_WIDTH, write data.
- r_row, in, RW, read row.
- r_col, in, CW, read column.
- dout, out, DATA_WIDTH, registered read data.
- taps, out, NUM_TAPS*DATA_WIDTH, registered row-0 cells; tap k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_ok, out, 1, registered pulse meaning the previous-cycle write was committed.
- busy, out, 1, clear engine active.

Behaviour:
- Reset:
  - Sets dout=0, taps=0, wr_ok=0, busy=1, state=CLEAR, clear counter=0.
  - No memory write occurs in a reset cycle.
  - Reset asserted mid-clear restarts the clear from cell 0.
- FSM state IDLE:
  - clr_req=1 moves to CLEAR with counter=0 and busy<=1.
  - A write in the same cycle as clr_req is dropped (wr_ok=0).
- FSM state CLEAR:
  - Each cycle writes FILL to linear cell cnt (row=cnt/COLS, col=cnt%COLS), then increments cnt.
  - At cnt==ROWS*COLS-1, writes the last cell, moves to IDLE and sets busy<=0 on the same edge.
  - busy is therefore high for exactly ROWS*COLS cycles after reset release or the clr_req edge.
  - While in CLEAR, clr_req is ignored and all writes are dropped.
- Write commit: in IDLE, requires we=1, w_row<ROWS, w_col<COLS, and, when FILTER_CTRL=1, din not 8'h0D and not 8'h0A. A committed write sets wr_ok=1 on the next cycle; otherwise wr_ok=0.
- Read:
  - Latency 1: dout<=mem[r_row][r_col]. An out-of-range address returns 0.
  - taps are updated every cycle from row 0.
  - A read of a cell written in the same cycle returns the old data (read-before-write).
  - Reads continue during CLEAR and return partially cleared contents.
- Widths: the clear counter is $clog2(ROWS*COLS) bits. Out-of-range addresses are possible because ROWS and COLS need not be powers of two.

Optional Feature:
- Macro: TEXT_FRAME_RAM_SCROLL_EN.
- With the macro defined:
  - Adds input port scroll (1 bit), a single-cycle pulse.
  - Adds a base-row register. Logical row r maps to physical row (r+base)%ROWS for writes, reads and taps.
  - scroll in IDLE: base<=(base+1)%ROWS, and enters CLEAR_ROW, which writes FILL to the old physical base row over exactly COLS cycles with busy=1. That row becomes logical row ROWS-1.
  - scroll during busy is ignored. clr_req has priority over scroll when both arrive in the same cycle.
  - reset and full clear set base=0.
- Without the macro: no scroll port, base fixed at 0, no CLEAR_ROW state.

Decomposition:
- Package text_frame_pkg contains:
  - state enum {IDLE, CLEAR, CLEAR_ROW};
  - CR=8'h0D and LF=8'h0A constants;
  - a function mapping logical (row, col) to a linear/physical index with an in-range flag.
- One sub-module, text_frame_clear_seq: the clear counter/FSM, outputs clear address, clear write enable and busy. The memory array and ports stay in the top.

Test Plan:
- Reset release, ROWS=32, COLS=4 -> busy high exactly 128 cycles; afterwards every cell reads 0 with 1-cycle latency.
- IDLE, write (2,3)=8'h41 -> wr_ok=1 next cycle; read (2,3) -> dout=8'h41 one cycle later; same-cycle read returned the old value 0.
- Write din=8'h0D and din=8'h0A with FILTER_CTRL=1 -> wr_ok=0 and cell unchanged; with FILTER_CTRL=0 -> both stored.
- Write (0,0)=8'h11 and (0,1)=8'h22 -> taps={8'h22,8'h11}. Then clr_req -> busy=1; a write at (0,0) during clear is dropped; taps read 0 after clear completes.
- ROWS=5, COLS=3: write row 6 -> dropped, wr_ok=0; read row 6 -> dout=0. Mid-clear reset -> busy held until 15 cycles after release.
- SCROLL_EN: write logical row 0 = 8'h55, then scroll -> busy for COLS=4 cycles; logical row 31 reads FILL; old logical row 1 data now appears at logical row 0.
